// File: rtl/uart_prog_loader_pkg.sv
// rtl/uart_prog_loader_pkg.sv - shared types and constants for the UART program loader
// Purpose: frame parser state encoding, fixed field sizes, sync default and
//          the address-field byte count helper.
package uart_prog_loader_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_TGT  = 3'd1,
    S_ADDR = 3'd2,
    S_LEN  = 3'd3,
    S_DATA = 3'd4,
    S_CHK  = 3'd5
  } state_e;

  localparam int          LEN_BYTES         = 2;
  localparam int          CHK_W             = 8;
  localparam logic [7:0]  SYNC_BYTE_DEFAULT = 8'hA5;
  localparam int          CNT_W             = 8;

  // Number of bytes carrying the word address on the wire.
  function automatic int addr_bytes(input int aw);
    return (aw + 7) / 8;
  endfunction

endpackage

// File: rtl/prog_byte_timer.sv
// rtl/prog_byte_timer.sv - inter-byte idle timer for the program loader
// Purpose: loadable down-counter; clr_i reloads Cycles, en_i counts down to
//          zero and holds there. Cycles == 0 disables expiry entirely.
// Ports:
//   clk_i      clock
//   rst_i      synchronous active-high reset (reloads)
//   clr_i      reload the counter
//   en_i       count down this cycle
//   expired_o  counter has reached zero (and timer is enabled)
module prog_byte_timer #(
  parameter int Cycles = 1_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int  CW      = (Cycles < 2) ? 1 : $clog2(Cycles + 1);
  localparam bit  ENABLED = (Cycles != 0);
  localparam logic [CW-1:0] LOAD = CW'(Cycles);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      cnt_q <= LOAD;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = ENABLED && (cnt_q == '0);

endmodule

// File: rtl/uart_prog_loader.sv
// rtl/uart_prog_loader.sv - framed, checksummed multi-target boot programmer
// Purpose: parses SYNC|TGT|ADDR|LEN|payload|CHK records from the programming
//          UART and writes assembled words into one of NumTargets memories,
//          holding the system in reset until a good LAST record arrives.
// Ports:
//   clk_i, rst_i          clock, synchronous active-high reset
//   prog_i                programming enable level
//   rx_dv_i, rx_byte_i    received byte strobe and data
//   we_o                  one-hot per-target write strobe (1-cycle)
//   addr_o, wdata_o       write address / data, held between writes
//   prog_rst_no           active-low system reset
//   busy_o                record in progress
//   done_o, err_o         good LAST record / error pulses
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int         DataWidth     = 32,
  parameter int         AddrWidth     = 12,
  parameter int         NumTargets    = 2,
  parameter int         TimeoutCycles = 1_000_000,
  parameter logic [7:0] SyncByte      = SYNC_BYTE_DEFAULT
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  prog_i,
  input  logic                  rx_dv_i,
  input  logic [7:0]            rx_byte_i,
  output logic [NumTargets-1:0] we_o,
  output logic [AddrWidth-1:0]  addr_o,
  output logic [DataWidth-1:0]  wdata_o,
  output logic                  prog_rst_no,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam int                    ADDR_B  = addr_bytes(AddrWidth);
  localparam int                    WORD_B  = DataWidth / 8;
  localparam logic [3:0]            NUM_TGT = 4'(NumTargets);
  localparam logic [NumTargets-1:0] TGT_ONE = NumTargets'(1);

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [2:0]             tgt_q, tgt_d;
  logic                   last_q, last_d;
  logic [AddrWidth-1:0]   waddr_q, waddr_d;
  logic [15:0]            len_q, len_d;
  logic [DataWidth-1:0]   word_q, word_d;
  logic [CHK_W-1:0]       chk_q, chk_d;
  logic                   armed_q, armed_d;
  logic [NumTargets-1:0]  we_q, we_d;
  logic [AddrWidth-1:0]   addr_o_q, addr_o_d;
  logic [DataWidth-1:0]   wdata_q, wdata_d;
  logic                   done_q, done_d;
  logic                   err_q, err_d;

  logic                   byte_ok;
  logic                   tmr_expired;
  logic [CHK_W-1:0]       chk_sum;

  assign byte_ok = rx_dv_i & prog_i;
  assign chk_sum = chk_q + rx_byte_i;

  // Idle time is only measured inside a record; any accepted byte or IDLE
  // keeps the timer topped up.
  prog_byte_timer #(
    .Cycles (TimeoutCycles)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (byte_ok || (state_q == S_IDLE)),
    .en_i      (state_q != S_IDLE),
    .expired_o (tmr_expired)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      tgt_q    <= '0;
      last_q   <= 1'b0;
      waddr_q  <= '0;
      len_q    <= '0;
      word_q   <= '0;
      chk_q    <= '0;
      armed_q  <= 1'b0;
      we_q     <= '0;
      addr_o_q <= '0;
      wdata_q  <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      last_q   <= last_d;
      waddr_q  <= waddr_d;
      len_q    <= len_d;
      word_q   <= word_d;
      chk_q    <= chk_d;
      armed_q  <= armed_d;
      we_q     <= we_d;
      addr_o_q <= addr_o_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    tgt_d    = tgt_q;
    last_d   = last_q;
    waddr_d  = waddr_q;
    len_d    = len_q;
    word_d   = word_q;
    chk_d    = chk_q;
    armed_d  = armed_q;
    we_d     = '0;
    addr_o_d = addr_o_q;
    wdata_d  = wdata_q;
    done_d   = 1'b0;
    err_d    = 1'b0;

    if ((state_q != S_IDLE) && !prog_i) begin
      // Programming withdrawn mid-record: abandon it, keep armed.
      err_d   = 1'b1;
      state_d = S_IDLE;
    end else if (byte_ok) begin
      case (state_q)
        S_IDLE: begin
          if (rx_byte_i == SyncByte) begin
            state_d = S_TGT;
            armed_d = 1'b1;
            chk_d   = '0;
          end
        end
        S_TGT: begin
          chk_d  = chk_sum;
          tgt_d  = rx_byte_i[2:0];
          last_d = rx_byte_i[7];
          cnt_d  = '0;
          if ({1'b0, rx_byte_i[2:0]} >= NUM_TGT) begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end else begin
            state_d = S_ADDR;
          end
        end
        S_ADDR: begin
          chk_d = chk_sum;
          // Address bytes beyond AddrWidth are discarded.
          for (int b = 0; b < 8; b++) begin
            if (int'(cnt_q) * 8 + b < AddrWidth) begin
              waddr_d[int'(cnt_q) * 8 + b] = rx_byte_i[b];
            end
          end
          if (cnt_q == CNT_W'(ADDR_B - 1)) begin
            cnt_d   = '0;
            state_d = S_LEN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_LEN: begin
          chk_d = chk_sum;
          len_d[int'(cnt_q) * 8 +: 8] = rx_byte_i;
          if (cnt_q == CNT_W'(LEN_BYTES - 1)) begin
            cnt_d   = '0;
            state_d = (len_d == 16'd0) ? S_CHK : S_DATA;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DATA: begin
          chk_d = chk_sum;
          word_d[int'(cnt_q) * 8 +: 8] = rx_byte_i;
          if (cnt_q == CNT_W'(WORD_B - 1)) begin
            cnt_d    = '0;
            we_d     = TGT_ONE << tgt_q;
            addr_o_d = waddr_q;
            wdata_d  = word_d;
            waddr_d  = waddr_q + 1'b1;
            if (len_q == 16'd1) begin
              state_d = S_CHK;
            end else begin
              len_d = len_q - 16'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_CHK: begin
          state_d = S_IDLE;
          if (rx_byte_i == chk_q) begin
            if (last_q) begin
              done_d  = 1'b1;
              armed_d = 1'b0;
            end
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if ((state_q != S_IDLE) && tmr_expired) begin
      err_d   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_comb begin
    we_o        = we_q;
    addr_o      = addr_o_q;
    wdata_o     = wdata_q;
    done_o      = done_q;
    err_o       = err_q;
    busy_o      = (state_q != S_IDLE);
    prog_rst_no = ~(armed_q | prog_i);
  end

endmodule

// File: tb/tb_uart_prog_loader.sv
// tb/tb_uart_prog_loader.sv - directed bench for uart_prog_loader
module tb_uart_prog_loader;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int NT = 2;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst;
  logic          prog;
  logic          rx_dv;
  logic [7:0]    rx_byte;
  logic [NT-1:0] we;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          prog_rst_n;
  logic          busy;
  logic          done;
  logic          err;

  int checks = 0;
  int errors = 0;

  uart_prog_loader #(
    .DataWidth     (DW),
    .AddrWidth     (AW),
    .NumTargets    (NT),
    .TimeoutCycles (TO),
    .SyncByte      (8'hA5)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .prog_i      (prog),
    .rx_dv_i     (rx_dv),
    .rx_byte_i   (rx_byte),
    .we_o        (we),
    .addr_o      (addr),
    .wdata_o     (wdata),
    .prog_rst_no (prog_rst_n),
    .busy_o      (busy),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NT-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t wr_q[$];
  int  done_cnt = 0;
  int  err_cnt  = 0;

  always @(negedge clk) begin
    if (we != '0) wr_q.push_back('{we, addr, wdata});
    if (done) done_cnt++;
    if (err)  err_cnt++;
  end

  typedef struct {
    logic [7:0]    tgt;
    logic [15:0]   addr;
    logic [15:0]   len;
    logic [63:0]   payload;
    bit            bad_chk;
    bit            short_frame;
    int            exp_n;
    logic [NT-1:0] exp_we;
    logic [AW-1:0] exp_a0;
    logic [AW-1:0] exp_a1;
    logic [DW-1:0] exp_d0;
    logic [DW-1:0] exp_d1;
    int            exp_done;
    int            exp_err;
  } vec_t;

  vec_t vecs[6];

  function automatic vec_t mk(input logic [7:0] tgt, input logic [15:0] a, input logic [15:0] len,
                              input bit bad, input bit shrt, input int n, input logic [NT-1:0] ewe,
                              input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                              input int edone, input int eerr);
    vec_t v;
    v.tgt = tgt; v.addr = a; v.len = len;
    v.payload = 64'h8877665544332211;
    v.bad_chk = bad; v.short_frame = shrt;
    v.exp_n = n; v.exp_we = ewe; v.exp_a0 = a0; v.exp_a1 = a1;
    v.exp_d0 = 32'h44332211; v.exp_d1 = 32'h88776655;
    v.exp_done = edone; v.exp_err = eerr;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_dv   = 1'b1;
    rx_byte = b;
    @(negedge clk);
    rx_dv   = 1'b0;
  endtask

  task automatic send_frame(input vec_t v);
    logic [7:0] sum;
    logic [7:0] b;
    sum = 8'h00;
    send_byte(8'hA5);
    send_byte(v.tgt);
    sum += v.tgt;
    if (!v.short_frame) begin
      send_byte(v.addr[7:0]);  sum += v.addr[7:0];
      send_byte(v.addr[15:8]); sum += v.addr[15:8];
      send_byte(v.len[7:0]);   sum += v.len[7:0];
      send_byte(v.len[15:8]);  sum += v.len[15:8];
      for (int i = 0; i < int'(v.len) * 4; i++) begin
        b = v.payload[8*i +: 8];
        send_byte(b);
        sum += b;
      end
      send_byte(v.bad_chk ? 8'h00 : sum);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int wb, db, eb, got;

    vecs[0] = mk(8'h00, 16'h0010, 16'd2, 1'b0, 1'b0, 2, 2'b01, 12'h010, 12'h011, 0, 0);
    vecs[1] = mk(8'h81, 16'h0010, 16'd2, 1'b0, 1'b0, 2, 2'b10, 12'h010, 12'h011, 1, 0);
    vecs[2] = mk(8'h00, 16'h0010, 16'd2, 1'b1, 1'b0, 2, 2'b01, 12'h010, 12'h011, 0, 1);
    vecs[3] = mk(8'h00, 16'h0FFF, 16'd2, 1'b0, 1'b0, 2, 2'b01, 12'hFFF, 12'h000, 0, 0);
    vecs[4] = mk(8'h05, 16'h0000, 16'd0, 1'b0, 1'b1, 0, 2'b00, 12'h000, 12'h000, 0, 1);
    vecs[5] = mk(8'h80, 16'h0020, 16'd0, 1'b0, 1'b0, 0, 2'b00, 12'h000, 12'h000, 1, 0);

    rst = 1'b1; prog = 1'b0; rx_dv = 1'b0; rx_byte = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_we",    64'(we), 0);
    check("rst_addr",  64'(addr), 0);
    check("rst_wdata", 64'(wdata), 0);
    check("rst_busy",  64'(busy), 0);
    check("rst_done",  64'(done), 0);
    check("rst_err",   64'(err), 0);
    check("rst_prn",   64'(prog_rst_n), 1);

    prog = 1'b1;
    #1;
    check("prog_prn", 64'(prog_rst_n), 0);

    for (int k = 0; k < 6; k++) begin
      wb = wr_q.size(); db = done_cnt; eb = err_cnt;
      send_frame(vecs[k]);
      repeat (4) @(negedge clk);
      check($sformatf("v%0d_nwr", k), 64'(wr_q.size() - wb), 64'(vecs[k].exp_n));
      if (wr_q.size() - wb >= 1 && vecs[k].exp_n >= 1) begin
        check($sformatf("v%0d_we0", k), 64'(wr_q[wb].we),   64'(vecs[k].exp_we));
        check($sformatf("v%0d_a0", k),  64'(wr_q[wb].addr), 64'(vecs[k].exp_a0));
        check($sformatf("v%0d_d0", k),  64'(wr_q[wb].data), 64'(vecs[k].exp_d0));
      end
      if (wr_q.size() - wb >= 2 && vecs[k].exp_n >= 2) begin
        check($sformatf("v%0d_we1", k), 64'(wr_q[wb+1].we),   64'(vecs[k].exp_we));
        check($sformatf("v%0d_a1", k),  64'(wr_q[wb+1].addr), 64'(vecs[k].exp_a1));
        check($sformatf("v%0d_d1", k),  64'(wr_q[wb+1].data), 64'(vecs[k].exp_d1));
      end
      check($sformatf("v%0d_done", k), 64'(done_cnt - db), 64'(vecs[k].exp_done));
      check($sformatf("v%0d_err", k),  64'(err_cnt - eb),  64'(vecs[k].exp_err));
      check($sformatf("v%0d_busy", k), 64'(busy), 0);
      check($sformatf("v%0d_prn", k),  64'(prog_rst_n), 0);
    end

    // Non-LAST good record leaves the system armed (held in reset).
    send_frame(vecs[0]);
    repeat (2) @(negedge clk);
    prog = 1'b0;
    #1;
    check("armed_hold_prn", 64'(prog_rst_n), 0);
    prog = 1'b1;
    repeat (2) @(negedge clk);

    // Good LAST record: done and reset release appear in the cycle after CHK.
    db = done_cnt;
    send_frame(vecs[1]);
    prog = 1'b0;
    #1;
    check("last_done", 64'(done), 1);
    check("last_prn",  64'(prog_rst_n), 1);
    prog = 1'b1;
    repeat (3) @(negedge clk);

    // Inter-byte timeout after the ADDR field.
    eb = err_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    repeat (90) @(negedge clk);
    check("to_early", 64'(err_cnt - eb), 0);
    got = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (err_cnt > eb) begin
        got = 1;
        break;
      end
    end
    check("to_err",  64'(got), 1);
    check("to_busy", 64'(busy), 0);

    // prog_i withdrawn during DATA.
    wb = wr_q.size(); eb = err_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h01); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22);
    @(negedge clk);
    prog = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_err",   64'(err_cnt - eb), 1);
    check("abort_busy",  64'(busy), 0);
    check("abort_nwr",   64'(wr_q.size() - wb), 0);
    check("abort_armed", 64'(prog_rst_n), 0);
    prog = 1'b1;
    @(negedge clk);

    // Reset mid-DATA: no strobes afterwards, armed cleared.
    wb = wr_q.size(); eb = err_cnt; db = done_cnt;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h10); send_byte(8'h00);
    send_byte(8'h02); send_byte(8'h00); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    send_byte(8'h44); send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
    repeat (3) @(negedge clk);
    check("rstmid_nwr",  64'(wr_q.size() - wb), 0);
    check("rstmid_busy", 64'(busy), 0);
    check("rstmid_err",  64'(err_cnt - eb), 0);
    check("rstmid_done", 64'(done_cnt - db), 0);
    check("rstmid_prn1", 64'(prog_rst_n), 0);
    prog = 1'b0;
    #1;
    check("rstmid_prn0", 64'(prog_rst_n), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
